// File: rtl/etapa_busqueda_if.sv
// Fetch-stage bus: ROM read port (req/ack) and downstream issue port (valid/ready).
// master = fetch stage; slave = ROM plus the control unit / datapath consumer.
//   rom_addr/rom_req -> ROM, rom_ack/rom_data <- ROM
//   instruction/operands/instr_valid -> downstream, instr_ready <- downstream
interface etapa_busqueda_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 20
);
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_req;
    logic               rom_ack;
    logic [INSTR_W-1:0] rom_data;
    logic [3:0]         instruction;
    logic [INSTR_W-5:0] operands;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output rom_addr, rom_req,
        input  rom_ack, rom_data,
        output instruction, operands, instr_valid,
        input  instr_ready
    );

    modport slave (
        input  rom_addr, rom_req,
        output rom_ack, rom_data,
        input  instruction, operands, instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage: PC, ROM read over req/ack, instruction register,
// and valid/ready issue of opcode + operands to the control unit.
// Ports: clk, rst (async, active-high), start, bus (etapa_busqueda_if.master),
//   pc (current program counter), halted (HALT opcode or fault),
//   fetch_err (stopped because ROM never acked within ACK_TIMEOUT cycles).
// Optional feature: define BUSQUEDA_JUMP_EN to make opcode 4'b0111 an
//   in-stage jump (pc <= operand low bits, never issued downstream).
module etapa_busqueda #(
    parameter int ADDR_W      = 8,
    parameter int INSTR_W     = 20,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    etapa_busqueda_if.master    bus,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic                fetch_err
);

    localparam logic [3:0] OPC_HALT = 4'hF;
    localparam int CNT_W =
        (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic [ADDR_W-1:0]  pc_n;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_n;
    logic [INSTR_W-1:0] ir_q;
    logic               ir_load;
    logic               err_n;
    logic [3:0]         opc_in;
    logic               is_jmp;

    assign opc_in = bus.rom_data[INSTR_W-1 -: 4];

`ifdef BUSQUEDA_JUMP_EN
    assign is_jmp = (opc_in == 4'h7);
`else
    assign is_jmp = 1'b0;
`endif

    assign bus.rom_addr    = pc;
    assign bus.instruction = ir_q[INSTR_W-1 -: 4];
    assign bus.operands    = ir_q[INSTR_W-5:0];

    always_comb begin
        state_n = state_q;
        pc_n    = pc;
        cnt_n   = cnt_q;
        ir_load = 1'b0;
        err_n   = fetch_err;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    cnt_n   = '0;
                end
            end
            FETCH: begin
                if (bus.rom_ack) begin
                    ir_load = 1'b1;
                    cnt_n   = '0;
                    if (opc_in == OPC_HALT) begin
                        state_n = HALT;
                    end else if (is_jmp) begin
                        // Jump resolves here; a fresh request for the
                        // target goes out next cycle.
                        pc_n = bus.rom_data[ADDR_W-1:0];
                    end else begin
                        state_n = ISSUE;
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                    if (ACK_TIMEOUT != 0 &&
                        cnt_n == CNT_W'(ACK_TIMEOUT)) begin
                        state_n = HALT;
                        err_n   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    pc_n    = pc + ADDR_W'(1);
                    state_n = FETCH;
                end
            end
            HALT: begin
                state_n = HALT;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state so they are
    // flop outputs aligned with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            pc              <= '0;
            cnt_q           <= '0;
            ir_q            <= '0;
            fetch_err       <= 1'b0;
            halted          <= 1'b0;
            bus.rom_req     <= 1'b0;
            bus.instr_valid <= 1'b0;
        end else begin
            state_q         <= state_n;
            pc              <= pc_n;
            cnt_q           <= cnt_n;
            fetch_err       <= err_n;
            halted          <= (state_n == HALT);
            bus.rom_req     <= (state_n == FETCH);
            bus.instr_valid <= (state_n == ISSUE);
            if (ir_load) begin
                ir_q <= bus.rom_data;
            end
        end
    end

endmodule

// File: tb/tb_etapa_busqueda.sv
// Testbench for etapa_busqueda: table vectors, directed corner sequences,
// and random programs checked against a program-walk reference model.
module tb_etapa_busqueda;

    localparam int AW = 4;
    localparam int IW = 20;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] pc;
    logic          halted;
    logic          fetch_err;

    etapa_busqueda_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    etapa_busqueda #(
        .ADDR_W(AW),
        .INSTR_W(IW),
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus.master),
        .pc(pc),
        .halted(halted),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] rom [16];
    int checks = 0;
    int errors = 0;
    int ack_lat;
    int ack_seen;
    int max_lat;
    bit ack_en;
    bit noise;

    typedef struct {
        logic [IW-1:0] word;
        bit            valid;
        logic [3:0]    op;
        logic [15:0]   ops;
        bit            halt;
        bit            req;
        logic [AW-1:0] addr;
    } vec_t;

    typedef struct {
        logic [IW-1:0] word;
        logic [AW-1:0] addr;
    } txn_t;

    vec_t vt [6];
    txn_t exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_rom();
        if (bus.rom_req && ack_en) begin
            if (ack_seen >= ack_lat) begin
                bus.rom_ack  = 1'b1;
                bus.rom_data = rom[bus.rom_addr];
                ack_seen     = 0;
                ack_lat      = $urandom_range(0, max_lat);
            end else begin
                bus.rom_ack  = 1'b0;
                bus.rom_data = IW'($urandom);
                ack_seen++;
            end
        end else begin
            bus.rom_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.rom_data = IW'($urandom);
        end
    endtask

    task automatic cyc(input bit rdy);
        drive_rom();
        bus.instr_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        start           = 1'b0;
        bus.rom_ack     = 1'b0;
        bus.rom_data    = '0;
        bus.instr_ready = 1'b0;
        ack_seen        = 0;
        ack_lat         = 0;
        max_lat         = 0;
        ack_en          = 1'b1;
        noise           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cyc(1'b0);
        start = 1'b0;
    endtask

    initial begin
        int n;
        bit found;

        vt[0] = '{20'h2_0123, 1, 4'h2, 16'h0123, 0, 0, 4'h0};
        vt[1] = '{20'hF_0000, 0, 4'hF, 16'h0000, 1, 0, 4'h0};
`ifdef BUSQUEDA_JUMP_EN
        vt[2] = '{20'h7_0009, 0, 4'h7, 16'h0009, 0, 1, 4'h9};
        vt[5] = '{20'h7_FFF5, 0, 4'h7, 16'hFFF5, 0, 1, 4'h5};
`else
        vt[2] = '{20'h7_0009, 1, 4'h7, 16'h0009, 0, 0, 4'h0};
        vt[5] = '{20'h7_FFF5, 1, 4'h7, 16'hFFF5, 0, 0, 4'h0};
`endif
        vt[3] = '{20'hE_ABCD, 1, 4'hE, 16'hABCD, 0, 0, 4'h0};
        vt[4] = '{20'h0_0000, 1, 4'h0, 16'h0000, 0, 0, 4'h0};

        // Reset state
        do_reset();
        chk("rst_req", 32'(bus.rom_req), 0);
        chk("rst_valid", 32'(bus.instr_valid), 0);
        chk("rst_instr", 32'(bus.instruction), 0);
        chk("rst_ops", 32'(bus.operands), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_halt", 32'(halted), 0);
        chk("rst_err", 32'(fetch_err), 0);

        // Single-word vectors, ack on the first FETCH cycle
        for (int i = 0; i < 6; i++) begin
            do_reset();
            rom[0] = vt[i].word;
            start_pulse();
            chk("vec_fetch_req", 32'(bus.rom_req), 1);
            cyc(1'b0);
            chk("vec_valid", 32'(bus.instr_valid), 32'(vt[i].valid));
            chk("vec_halt", 32'(halted), 32'(vt[i].halt));
            chk("vec_req", 32'(bus.rom_req), 32'(vt[i].req));
            chk("vec_pc", 32'(pc), 32'(vt[i].addr));
            chk("vec_addr", 32'(bus.rom_addr), 32'(vt[i].addr));
            if (vt[i].valid) begin
                chk("vec_instr", 32'(bus.instruction), 32'(vt[i].op));
                chk("vec_ops", 32'(bus.operands), 32'(vt[i].ops));
            end
        end

        // Backpressure: 5 stalled cycles, then accept
        do_reset();
        rom[0] = 20'h2_0123;
        rom[1] = 20'h3_0456;
        start_pulse();
        cyc(1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0);
            chk("stall_valid", 32'(bus.instr_valid), 1);
            chk("stall_instr", 32'(bus.instruction), 32'h2);
            chk("stall_ops", 32'(bus.operands), 32'h0123);
            chk("stall_pc", 32'(pc), 0);
            chk("stall_req", 32'(bus.rom_req), 0);
        end
        cyc(1'b1);
        chk("acc_pc", 32'(pc), 1);
        chk("acc_valid", 32'(bus.instr_valid), 0);
        chk("acc_req", 32'(bus.rom_req), 1);
        chk("acc_addr", 32'(bus.rom_addr), 1);

        // HALT opcode at address 3
        do_reset();
        for (int a = 0; a < 16; a++) rom[a] = {4'h1, 12'h0, 4'(a)};
        rom[3] = 20'hF_0000;
        start_pulse();
        n = 0;
        for (int i = 0; i < 40 && !halted; i++) begin
            if (bus.instr_valid) n++;
            cyc(1'b1);
        end
        chk("halt_issued", 32'(n), 3);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_pc", 32'(pc), 3);
        chk("halt_err", 32'(fetch_err), 0);
        start = 1'b1;
        repeat (4) cyc(1'b1);
        start = 1'b0;
        chk("halt_start_ign", 32'(halted), 1);
        chk("halt_start_pc", 32'(pc), 3);
        chk("halt_start_req", 32'(bus.rom_req), 0);
        chk("halt_start_val", 32'(bus.instr_valid), 0);
        #2 rst = 1'b1;
        #1;
        chk("halt_rst_pc", 32'(pc), 0);
        chk("halt_rst_flag", 32'(halted), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b0);
        chk("idle_no_req", 32'(bus.rom_req), 0);
        start_pulse();
        chk("idle_start_req", 32'(bus.rom_req), 1);

        // Ack timeout
        do_reset();
        ack_en = 1'b0;
        start_pulse();
        n = 0;
        for (int i = 0; i < 50 && !halted; i++) begin
            if (bus.rom_req) n++;
            cyc(1'b0);
        end
        chk("to_cycles", 32'(n), TO);
        chk("to_halt", 32'(halted), 1);
        chk("to_err", 32'(fetch_err), 1);
        chk("to_req", 32'(bus.rom_req), 0);

        // Async reset in the middle of a request
        do_reset();
        ack_en = 1'b0;
        start_pulse();
        cyc(1'b0);
        chk("mid_req_pre", 32'(bus.rom_req), 1);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus.rom_req), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // PC wrap from 15 to 0
        do_reset();
        for (int a = 0; a < 16; a++) rom[a] = {4'h1, 12'h0, 4'(a)};
        start_pulse();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (bus.instr_valid && pc == 4'hF) begin
                cyc(1'b1);
                chk("wrap_pc", 32'(pc), 0);
                chk("wrap_req", 32'(bus.rom_req), 1);
                chk("wrap_addr", 32'(bus.rom_addr), 0);
                found = 1'b1;
            end else begin
                cyc(1'b1);
            end
        end
        chk("wrap_reached", 32'(found), 1);

        // Random programs vs. program-walk model
        for (int p = 0; p < 20; p++) begin
            int k;
            do_reset();
            for (int a = 0; a < 16; a++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 14));
`ifdef BUSQUEDA_JUMP_EN
                if (op == 4'h7) op = 4'h6;
`endif
                rom[a] = {op, 16'($urandom)};
            end
            k = $urandom_range(1, 15);
            rom[k] = {4'hF, 16'($urandom)};
            exp_q.delete();
            for (int a = 0; a < k; a++) exp_q.push_back('{rom[a], 4'(a)});
            noise   = 1'b1;
            max_lat = 3;
            ack_lat = $urandom_range(0, max_lat);
            start_pulse();
            for (int i = 0; i < 500 && !halted; i++) begin
                bit rdy;
                bit acc;
                bit held;
                logic [3:0]    s_op;
                logic [15:0]   s_ops;
                logic [AW-1:0] s_pc;
                rdy   = 1'($urandom_range(0, 1));
                acc   = bus.instr_valid && rdy;
                held  = bus.instr_valid && !rdy;
                s_op  = bus.instruction;
                s_ops = bus.operands;
                s_pc  = pc;
                cyc(rdy);
                chk("rnd_excl", 32'(bus.rom_req && bus.instr_valid), 0);
                if (acc) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd_extra", 32'(acc), 0);
                    end else begin
                        txn_t t;
                        t = exp_q.pop_front();
                        chk("rnd_op", 32'(s_op), 32'(t.word[19:16]));
                        chk("rnd_ops", 32'(s_ops), 32'(t.word[15:0]));
                        chk("rnd_pc", 32'(s_pc), 32'(t.addr));
                    end
                end
                if (held) begin
                    chk("rnd_hold_v", 32'(bus.instr_valid), 1);
                    chk("rnd_hold_op", 32'(bus.instruction), 32'(s_op));
                    chk("rnd_hold_ops", 32'(bus.operands), 32'(s_ops));
                    chk("rnd_hold_pc", 32'(pc), 32'(s_pc));
                end
            end
            chk("rnd_halt", 32'(halted), 1);
            chk("rnd_err", 32'(fetch_err), 0);
            chk("rnd_final_pc", 32'(pc), 32'(k));
            chk("rnd_left", 32'(exp_q.size()), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
